step_pulse_generator: RTL and testbench

- Consumer side of the solution table: reads the three per-axis t_off/dir entries, which are continuously presented, and turns them into timed step pulses plus direction levels for the axis drivers.
- Each frame starts on a request. The block snapshots all entries into shadow registers, so the table can be rewritten mid-frame.
- It then runs a cycle counter and fires each axis's step pulse when the counter reaches that axis's t_off.

---
 rtl/t0_step_pkg.sv | 15 +
 rtl/step_pulse_generator_channel.sv | 85 ++++++++
 rtl/step_pulse_generator.sv | 120 ++++++++++++
 tb/tb_step_pulse_generator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t0_step_pkg.sv
// Shared defaults and types for the step pulse generator and its per-axis channels.
package t0_step_pkg;

    localparam int TW_DEF     = 32;
    localparam int N_AXES_DEF = 3;

    // t_off value meaning "this axis does not step in this frame"
    localparam logic [TW_DEF-1:0] T_OFF_NONE = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } step_state_t;

endpackage

// File: rtl/step_pulse_generator_channel.sv
// One axis: shadowed t_off/dir, registered hit compare, pulse-width down-counter,
// and a direction output that only moves while the step line is quiet.
module step_channel
    import t0_step_pkg::*;
#(
    parameter int TW      = TW_DEF,
    parameter int PULSE_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_capture,
    input  logic          i_run,
    input  logic [TW-1:0] i_cnt,
    input  logic [TW-1:0] i_len,
    input  logic [TW-1:0] i_t_off,
    input  logic          i_dir,
    output logic          o_step,
    output logic          o_dir,
    output logic          o_overrun
);

    localparam int             PCW = 8;
    localparam logic [PCW-1:0] PW  = PCW'(PULSE_W);

    logic [TW-1:0]  r_t_off;
    logic           r_dir_sh;
    logic           r_dir_pend;
    logic           r_dir;
    logic           r_hit;
    logic [PCW-1:0] r_pcnt;

    logic           w_hit;
    logic           w_busy_next;
    logic           w_dir_load;

    // all-ones means "no step"; offsets past the frame end never fire
    assign w_hit = i_run && (i_cnt == r_t_off) && (r_t_off != '1) && (r_t_off < i_len);

    // current pulse still owns the next cycle, so a new hit cannot start one
    assign w_busy_next = (r_pcnt > PCW'(1));
    assign o_overrun   = r_hit && w_busy_next;

    // direction moves only at an edge where step is low before and after
    assign w_dir_load = r_dir_pend && (r_pcnt == '0) && !r_hit;

    assign o_step = (r_pcnt != '0);
    assign o_dir  = r_dir;

    // Snapshot this axis' table entry when a frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_off  <= '0;
            r_dir_sh <= 1'b0;
        end else if (i_capture) begin
            r_t_off  <= i_t_off;
            r_dir_sh <= i_dir;
        end
    end

    // Register the compare; this extra stage gives dir_out its setup cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hit <= 1'b0;
        else        r_hit <= w_hit;
    end

    // Pulse counter: reload on an accepted hit, otherwise run down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_pcnt <= '0;
        else if (r_hit && !w_busy_next) r_pcnt <= PW;
        else if (r_pcnt != '0)         r_pcnt <= r_pcnt - PCW'(1);
    end

    // Deferred direction load; a new capture re-arms the pending load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir      <= 1'b0;
            r_dir_pend <= 1'b0;
        end else begin
            if (w_dir_load) r_dir <= r_dir_sh;
            if (i_capture)       r_dir_pend <= 1'b1;
            else if (w_dir_load) r_dir_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/step_pulse_generator.sv
// Frame sequencer: accepts frame requests, runs the frame counter and feeds
// one step_channel per axis; collects channel overruns into a sticky flag.
module step_pulse_generator
    import t0_step_pkg::*;
#(
    parameter int N_AXES  = N_AXES_DEF,
    parameter int TW      = TW_DEF,
    parameter int PULSE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TW-1:0]     t_off [0:N_AXES-1],
    input  logic              dir   [0:N_AXES-1],
    input  logic [TW-1:0]     frame_len,
    input  logic              frame_start,
    output logic              frame_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [N_AXES-1:0] step,
    output logic [N_AXES-1:0] dir_out,
    output logic              err_overrun,
    input  logic              err_clr
);

    step_state_t       r_state;
    step_state_t       w_state_nxt;
    logic [TW-1:0]     r_cnt;
    logic [TW-1:0]     r_len_sh;
    logic              r_frame_done;
    logic              r_err;

    logic [TW-1:0]     w_len;
    logic              w_run;
    logic              w_last;
    logic              w_ready;
    logic              w_capture;
    logic [N_AXES-1:0] w_ovr;

    // a zero-length request runs as a one-cycle frame
    assign w_len     = (r_len_sh == '0) ? TW'(1) : r_len_sh;
    assign w_run     = (r_state == RUN);
    assign w_last    = w_run && (r_cnt == w_len - TW'(1));
    assign w_capture = w_ready && frame_start;

    assign frame_ready = w_ready;
    assign busy        = w_run;
    assign frame_done  = r_frame_done;
    assign err_overrun = r_err;

    // Next state and frame_ready; the last RUN cycle accepts a back-to-back frame.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (frame_start) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) begin
                    w_ready     = 1'b1;
                    w_state_nxt = frame_start ? RUN : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Frame counter and frame length shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_len_sh <= '0;
        end else if (w_capture) begin
            r_cnt    <= '0;
            r_len_sh <= frame_len;
        end else if (w_run) begin
            r_cnt    <= r_cnt + TW'(1);
        end
    end

    // frame_done follows the last frame cycle by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_frame_done <= 1'b0;
        else        r_frame_done <= w_last;
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_err <= 1'b0;
        else if (|w_ovr)  r_err <= 1'b1;
        else if (err_clr) r_err <= 1'b0;
    end

    for (genvar gi = 0; gi < N_AXES; gi++) begin : g_ch
        step_channel #(
            .TW      (TW),
            .PULSE_W (PULSE_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_capture (w_capture),
            .i_run     (w_run),
            .i_cnt     (r_cnt),
            .i_len     (w_len),
            .i_t_off   (t_off[gi]),
            .i_dir     (dir[gi]),
            .o_step    (step[gi]),
            .o_dir     (dir_out[gi]),
            .o_overrun (w_ovr[gi])
        );
    end

endmodule

// File: tb/tb_step_pulse_generator.sv
// Bench for step_pulse_generator: stimulus schedules expected pulse intervals,
// frame ends and error events on an absolute cycle timeline; a monitor compares
// every cycle's outputs against the queued expectation.
module tb_step_pulse_generator;
    import t0_step_pkg::*;

    localparam int NA   = 3;
    localparam int PW   = 4;
    localparam int MAXC = 4096;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   t_off [0:NA-1];
    logic          dir   [0:NA-1];
    logic [31:0]   frame_len;
    logic          frame_start;
    logic          err_clr;
    logic          frame_ready, busy, frame_done, err_overrun;
    logic [NA-1:0] step, dir_out;

    step_pulse_generator #(.N_AXES(NA), .TW(32), .PULSE_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .t_off(t_off), .dir(dir), .frame_len(frame_len),
        .frame_start(frame_start), .frame_ready(frame_ready), .busy(busy),
        .frame_done(frame_done), .step(step), .dir_out(dir_out),
        .err_overrun(err_overrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   cyc;
        logic [NA-1:0] step;
        logic [NA-1:0] dir;
        logic          busy;
        logic          rdy;
        logic          done;
        logic          err;
    } exp_t;

    exp_t q[$];
    exp_t mx, ma;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 0;

    // reference timeline: which cycles each axis is stepping, frame_done cycles,
    // cycles where the overrun flag gets set
    bit st [NA][MAXC];
    bit dn [MAXC];
    bit es [MAXC];
    int n, cur_end;
    int last_end [NA];
    bit pend [NA];
    bit pval [NA];
    bit dout [NA];
    bit e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NA; i++) begin
            for (int k = 0; k < MAXC; k++) st[i][k] = 0;
            last_end[i] = -100;
            pend[i] = 0; pval[i] = 0; dout[i] = 0;
        end
        for (int k = 0; k < MAXC; k++) begin dn[k] = 0; es[k] = 0; end
        n = 0; cur_end = -1; e = 0;
    endfunction

    // Effect of clock edge n with the inputs currently driven; pushes cycle n's outputs.
    function automatic void model_edge(input bit fs, input bit clr);
        exp_t x;
        int   ln, r;
        // direction can only change where step is low in the cycles on both sides
        for (int i = 0; i < NA; i++)
            if (pend[i] && !st[i][n-1] && !st[i][n]) begin dout[i] = pval[i]; pend[i] = 0; end
        // a request is taken when the previous cycle was idle or the last frame cycle
        if (fs && cur_end <= n - 1) begin
            ln = (frame_len == 0) ? 1 : int'(frame_len);
            cur_end = n + ln - 1;
            dn[n + ln] = 1;
            for (int i = 0; i < NA; i++) begin
                pend[i] = 1; pval[i] = dir[i];
                if (t_off[i] != NONE && t_off[i] < 32'(ln)) begin
                    r = n + 2 + int'(t_off[i]);
                    if (r <= last_end[i]) es[r] = 1;
                    else begin
                        for (int k = r; k < r + PW; k++) st[i][k] = 1;
                        last_end[i] = r + PW - 1;
                    end
                end
            end
        end
        e = es[n] ? 1'b1 : (clr ? 1'b0 : e);
        x.cyc = 16'(n);
        for (int i = 0; i < NA; i++) begin x.step[i] = st[i][n]; x.dir[i] = dout[i]; end
        x.busy = (n <= cur_end);
        x.rdy  = (n > cur_end) || (n == cur_end);
        x.done = dn[n];
        x.err  = e;
        q.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL trace: no expectation queued, got step=%b", step);
            end else begin
                mx = q.pop_front();
                ma = mx;
                ma.step = step; ma.dir = dir_out; ma.busy = busy;
                ma.rdy = frame_ready; ma.done = frame_done; ma.err = err_overrun;
                if (ma !== mx) begin
                    bad++;
                    $display("FAIL trace cyc=%0d: got step=%b dir=%b busy=%b rdy=%b done=%b err=%b want step=%b dir=%b busy=%b rdy=%b done=%b err=%b",
                             mx.cyc, ma.step, ma.dir, ma.busy, ma.rdy, ma.done, ma.err,
                             mx.step, mx.dir, mx.busy, mx.rdy, mx.done, mx.err);
                end
            end
        end
    end

    task automatic edge_go(input bit fs, input bit clr);
        frame_start = fs;
        err_clr     = clr;
        n++;
        model_edge(fs, clr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_idle(input int cycles);
        for (int k = 0; k < cycles; k++) edge_go(1'b0, 1'b0);
    endtask

    task automatic set_tab(input logic [31:0] t0, t1, t2, input bit d0, d1, d2);
        t_off[0] = t0; t_off[1] = t1; t_off[2] = t2;
        dir[0] = d0; dir[1] = d1; dir[2] = d2;
    endtask

    task automatic do_reset();
        mon_en = 0;
        q.delete();
        rst_n = 0; frame_start = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        chk("reset step", 32'(step), 0);
        chk("reset dir_out", 32'(dir_out), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset frame_done", 32'(frame_done), 0);
        chk("reset err", 32'(err_overrun), 0);
        chk("reset ready", 32'(frame_ready), 1);
        #1 mon_en = 1;
    endtask

    initial begin
        set_tab(0, 0, 0, 0, 0, 0);
        frame_len = 0; frame_start = 0; err_clr = 0;

        // basic frame
        do_reset();
        set_tab(2, 5, NONE, 1, 0, 1); frame_len = 10;
        edge_go(1, 0);
        run_idle(14);

        // back-to-back frames, pulses abut without overrun
        set_tab(0, NONE, NONE, 1, 1, 0); frame_len = 4;
        for (int k = 0; k < 16; k++) edge_go(1, 0);
        run_idle(8);
        // shorter frames than the pulse: overrun, then clear
        frame_len = 2;
        for (int k = 0; k < 6; k++) edge_go(1, 0);
        run_idle(3);
        edge_go(0, 1);
        run_idle(6);

        // direction change requested while a pulse is active
        set_tab(1, NONE, NONE, 0, 0, 0); frame_len = 2;
        edge_go(1, 0);
        dir[0] = 1;
        edge_go(0, 0);
        edge_go(1, 0);
        run_idle(10);

        // offsets at the frame boundary and zero-length frame
        set_tab(NONE, 10, NONE, 0, 1, 0); frame_len = 10;
        edge_go(1, 0);
        run_idle(12);
        set_tab(0, NONE, NONE, 1, 1, 1); frame_len = 0;
        edge_go(1, 0);
        run_idle(6);

        // table rewritten mid-frame
        set_tab(1, 3, 6, 1, 0, 1); frame_len = 8;
        edge_go(1, 0);
        set_tab(0, 0, 0, 0, 1, 0); frame_len = 3;
        run_idle(3);
        edge_go(1, 0);
        run_idle(4);
        edge_go(1, 0);
        run_idle(12);

        // async reset in the middle of a pulse and a frame
        set_tab(0, 1, NONE, 1, 1, 0); frame_len = 6;
        edge_go(1, 0);
        frame_start = 0;
        run_idle(3);
        @(posedge clk);
        #2;
        mon_en = 0;
        q.delete();
        rst_n = 0;
        #1;
        chk("async rst step", 32'(step), 0);
        chk("async rst dir_out", 32'(dir_out), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst ready", 32'(frame_ready), 1);
        chk("async rst done", 32'(frame_done), 0);
        do_reset();

        // randomized frames, table rewritten every cycle
        for (int k = 0; k < 1500; k++) begin
            frame_len = 32'($urandom_range(0, 6));
            for (int i = 0; i < NA; i++) begin
                t_off[i] = ($urandom_range(0, 7) == 0) ? NONE : 32'($urandom_range(0, 7));
                dir[i]   = 1'($urandom_range(0, 1));
            end
            edge_go(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        run_idle(16);

        #1 mon_en = 0;
        chk("queue drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
